// File: rtl/parity_accumulator.sv
// Streaming XOR/XNOR column-parity accumulator with valid/ready handshaking.
// Folds a frame of WIDTH-bit beats into a parity word, an overall parity bit and a beat count.
module parity_accumulator #(
    parameter int unsigned  WIDTH   = 8,
    parameter int unsigned  MAX_LEN = 16,
    parameter bit           ODD     = 1'b0,
    localparam int unsigned CW      = $clog2(MAX_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_last,
    output logic             o_par_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_par_word,
    output logic             o_par_bit,
    output logic [CW-1:0]    o_word_count,
    output logic             o_err
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_acc_bit;
    logic [CW-1:0]    r_count;
    logic             r_par_valid;
    logic             r_err;

    logic w_accept;
    logic w_handoff;
    logic w_in_bit;
    logic w_full;

    assign o_in_ready = (r_state != StHold) & ~i_rst;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_handoff  = r_par_valid & i_out_ready;
    assign w_in_bit   = ^i_in_data;
    // The beat being accepted now is the MAX_LEN-th one.
    assign w_full     = (r_count == CW'(MAX_LEN - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_acc_bit   <= 1'b0;
            r_count     <= '0;
            r_par_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_acc     <= i_in_data;
                        r_acc_bit <= w_in_bit;
                        r_count   <= CW'(1);
                        if (i_in_last || MAX_LEN == 1) begin
                            r_state     <= StHold;
                            r_par_valid <= 1'b1;
                        end else begin
                            r_state <= StAcc;
                        end
                    end
                end
                StAcc: begin
                    if (w_accept) begin
                        r_acc     <= r_acc ^ i_in_data;
                        r_acc_bit <= r_acc_bit ^ w_in_bit;
                        r_count   <= r_count + 1'b1;
                        if (i_in_last) begin
                            r_state     <= StHold;
                            r_par_valid <= 1'b1;
                        end else if (w_full) begin
                            // Truncate: keep this beat, refuse the rest.
                            r_state     <= StHold;
                            r_par_valid <= 1'b1;
                            r_err       <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (w_handoff) begin
                        r_state     <= StIdle;
                        r_par_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_count     <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_par_valid  = r_par_valid;
    assign o_par_word   = r_acc ^ {WIDTH{ODD}};
    assign o_par_bit    = r_acc_bit ^ ODD;
    assign o_word_count = r_count;
    assign o_err        = r_err;

endmodule

// File: tb/tb_parity_accumulator.sv
// Bench for parity_accumulator: three instances (even/16, odd/16, even/4) driven by
// directed and random frames, checked against a frame-level XOR model.
module tb_parity_accumulator;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld  [N];
    logic       lst  [N];
    logic       ordy [N];
    logic [7:0] dat  [N];
    logic       rdy  [N];
    logic       pv   [N];
    logic       pb   [N];
    logic       er   [N];
    logic [7:0] pw   [N];
    logic [4:0] wc0;
    logic [4:0] wc1;
    logic [2:0] wc2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parity_accumulator u_even (
        .i_clk(clk), .i_rst(rst), .i_in_valid(vld[0]), .o_in_ready(rdy[0]),
        .i_in_data(dat[0]), .i_in_last(lst[0]), .o_par_valid(pv[0]), .i_out_ready(ordy[0]),
        .o_par_word(pw[0]), .o_par_bit(pb[0]), .o_word_count(wc0), .o_err(er[0])
    );

    parity_accumulator #(.ODD(1'b1)) u_odd (
        .i_clk(clk), .i_rst(rst), .i_in_valid(vld[1]), .o_in_ready(rdy[1]),
        .i_in_data(dat[1]), .i_in_last(lst[1]), .o_par_valid(pv[1]), .i_out_ready(ordy[1]),
        .o_par_word(pw[1]), .o_par_bit(pb[1]), .o_word_count(wc1), .o_err(er[1])
    );

    parity_accumulator #(.MAX_LEN(4)) u_short (
        .i_clk(clk), .i_rst(rst), .i_in_valid(vld[2]), .o_in_ready(rdy[2]),
        .i_in_data(dat[2]), .i_in_last(lst[2]), .o_par_valid(pv[2]), .i_out_ready(ordy[2]),
        .o_par_word(pw[2]), .o_par_bit(pb[2]), .o_word_count(wc2), .o_err(er[2])
    );

    function automatic int max_of(input int k);
        return (k == 2) ? 4 : 16;
    endfunction

    function automatic bit odd_of(input int k);
        return k == 1;
    endfunction

    function automatic logic [4:0] wc_of(input int k);
        case (k)
            0:       return wc0;
            1:       return wc1;
            default: return {2'b00, wc2};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends beats to instance k, then checks the result, backpressure and handoff.
    task automatic run_frame(input int k, input logic [7:0] beats[$], input bit with_last,
                             input int gap_min, input int gap_max, input int bp);
        logic [7:0] e_acc;
        logic [7:0] e_word;
        logic       e_bit;
        int         e_cnt;
        bit         e_err;
        bit         closed;
        bit         is_last;
        int         i;
        int         guard;
        e_acc  = '0;
        e_cnt  = 0;
        e_err  = 1'b0;
        closed = 1'b0;
        i      = 0;
        while (i < beats.size() && !closed) begin
            is_last = with_last && (i == beats.size() - 1);
            vld[k]  = 1'b1;
            dat[k]  = beats[i];
            lst[k]  = is_last;
            guard   = 0;
            while (!rdy[k] && guard < 20) begin
                step();
                guard++;
            end
            total++;
            if (guard >= 20) begin
                bad++;
                $display("FAIL accept_wait k=%0d beat=%0d ready=%0b want=1", k, i, rdy[k]);
            end
            step();
            e_acc ^= beats[i];
            e_cnt++;
            if (is_last) begin
                closed = 1'b1;
            end else if (e_cnt == max_of(k)) begin
                closed = 1'b1;
                e_err  = (e_cnt > 1);
            end
            i++;
            vld[k] = 1'b0;
            lst[k] = 1'b0;
            total++;
            if (pv[k] !== closed) begin
                bad++;
                $display("FAIL par_valid_timing k=%0d beat=%0d got=%0b want=%0b",
                         k, i, pv[k], closed);
            end
            if (!closed) begin
                repeat ($urandom_range(gap_max, gap_min)) begin
                    dat[k] = 8'($urandom);
                    lst[k] = 1'($urandom);
                    step();
                end
                lst[k] = 1'b0;
            end
        end
        e_word = e_acc ^ {8{odd_of(k)}};
        e_bit  = (^e_acc) ^ odd_of(k);
        // Upstream keeps offering a beat (the refused overflow beat if there is one).
        vld[k] = 1'b1;
        dat[k] = (i < beats.size()) ? beats[i] : 8'($urandom);
        for (int c = 0; c <= bp; c++) begin
            total++;
            if ({pv[k], rdy[k], pw[k], pb[k], wc_of(k), er[k]} !==
                {1'b1, 1'b0, e_word, e_bit, 5'(e_cnt), e_err}) begin
                bad++;
                $display("FAIL hold_result k=%0d cyc=%0d got v=%0b r=%0b w=%h b=%0b n=%0d e=%0b want v=1 r=0 w=%h b=%0b n=%0d e=%0b",
                         k, c, pv[k], rdy[k], pw[k], pb[k], wc_of(k), er[k],
                         e_word, e_bit, e_cnt, e_err);
            end
            if (c < bp) step();
        end
        vld[k]  = 1'b0;
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        total++;
        if ({pv[k], er[k], wc_of(k), rdy[k]} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL handoff_clear k=%0d got v=%0b e=%0b n=%0d r=%0b want v=0 e=0 n=0 r=1",
                     k, pv[k], er[k], wc_of(k), rdy[k]);
        end
    endtask

    task automatic test_reset();
        vld[0] = 1'b1; dat[0] = 8'h3C; lst[0] = 1'b0;
        vld[1] = 1'b1; dat[1] = 8'h81; lst[1] = 1'b1;
        step();
        vld[0] = 1'b0; vld[1] = 1'b0; lst[1] = 1'b0;
        total++;
        if (wc0 !== 5'd1 || pv[1] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_state got n0=%0d v1=%0b want n0=1 v1=1", wc0, pv[1]);
        end
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if ({pv[k], er[k], wc_of(k), rdy[k]} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
                bad++;
                $display("FAIL async_reset k=%0d got v=%0b e=%0b n=%0d r=%0b want 0 0 0 0",
                         k, pv[k], er[k], wc_of(k), rdy[k]);
            end
        end
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (rdy[k] !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_reset k=%0d got=%0b want=1", k, rdy[k]);
            end
        end
    endtask

    task automatic test_three_beat();
        logic [7:0] q[$];
        q.push_back(8'h0F); q.push_back(8'hF0); q.push_back(8'hFF);
        run_frame(0, q, 1'b1, 0, 0, 0);
    endtask

    task automatic test_single_beat();
        logic [7:0] q[$];
        q.push_back(8'hA5);
        run_frame(0, q, 1'b1, 0, 0, 0);
        run_frame(1, q, 1'b1, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        for (int j = 0; j < 4; j++) q.push_back(8'($urandom));
        run_frame(0, q, 1'b1, 0, 0, 5);
        q.delete();
        for (int j = 0; j < 3; j++) q.push_back(8'($urandom));
        run_frame(0, q, 1'b1, 0, 0, 0);
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h04);
        q.push_back(8'h08); q.push_back(8'h10);
        run_frame(2, q, 1'b0, 0, 0, 3);
    endtask

    task automatic test_gaps_reset();
        logic [7:0] q[$];
        q.push_back(8'h11); q.push_back(8'h22);
        run_frame(0, q, 1'b1, 2, 2, 0);
        vld[0] = 1'b1; dat[0] = 8'h5A; lst[0] = 1'b0;
        step();
        vld[0] = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({pv[0], wc0} !== {1'b0, 5'd0}) begin
                bad++;
                $display("FAIL drop_after_reset cyc=%0d got v=%0b n=%0d want v=0 n=0",
                         c, pv[0], wc0);
            end
        end
        q.delete();
        q.push_back(8'hC3); q.push_back(8'h3C); q.push_back(8'h77);
        run_frame(0, q, 1'b1, 0, 1, 1);
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         k;
        int         n;
        bit         wl;
        for (int f = 0; f < 40; f++) begin
            k  = $urandom_range(N - 1, 0);
            n  = $urandom_range(20, 1);
            wl = (n > max_of(k)) ? 1'($urandom) : 1'b1;
            q.delete();
            for (int j = 0; j < n; j++) q.push_back(8'($urandom));
            run_frame(k, q, wl, 0, 2, $urandom_range(3, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            vld[k] = 1'b0; lst[k] = 1'b0; ordy[k] = 1'b0; dat[k] = '0;
        end
        repeat (2) step();
        rst = 1'b0;
        #1;
        test_reset();
        test_three_beat();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_gaps_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
